// File: rtl/loopback_nch.sv
`default_nettype none
// ============================================================================
// Module   : loopback_nch
// Purpose  : Multi-channel USB CDC loopback engine. Each channel owns a byte
//            FIFO. Host OUT bytes are routed into the FIFOs as direct
//            loopback, rotated to the next channel, or discarded (sink). The
//            FIFOs drain to the host IN side. A stretched activity LED is
//            driven from any OUT/IN transfer.
// Revision : 1.0 - initial release
// ============================================================================
module loopback_nch #(
    parameter int CHANNELS         = 2,
    parameter int DEPTH            = 16,
    parameter int LED_STRETCH_BITS = 20
) (
    input  logic                                  clk_i,
    input  logic                                  rstn_i,
    input  logic [1:0]                            mode_i,
    input  logic [8*CHANNELS-1:0]                 out_data_i,
    input  logic [CHANNELS-1:0]                   out_valid_i,
    output logic [CHANNELS-1:0]                   out_ready_o,
    output logic [8*CHANNELS-1:0]                 in_data_o,
    output logic [CHANNELS-1:0]                   in_valid_o,
    input  logic [CHANNELS-1:0]                   in_ready_i,
    output logic [CHANNELS*($clog2(DEPTH)+1)-1:0] level_o,
    output logic [1:0]                            mode_o,
    output logic                                  led_o
);

    localparam int            AW          = $clog2(DEPTH);
    localparam int            LW          = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL  = LW'(DEPTH);
    localparam logic [1:0]    MODE_ROTATE = 2'd1;
    localparam logic [1:0]    MODE_SINK   = 2'd2;

    logic [1:0]                  mode_q, mode_d;
    logic [LED_STRETCH_BITS-1:0] led_cnt_q, led_cnt_d;

    logic                is_sink;
    logic                is_rot;
    logic [CHANNELS-1:0] is_full;
    logic [CHANNELS-1:0] wr_en;
    logic [CHANNELS-1:0] rd_en;
    logic                any_xfer;
    logic                all_empty;

    // Mode 3 is not decoded, so it behaves as direct loopback.
    assign is_sink = (mode_q == MODE_SINK);
    assign is_rot  = (mode_q == MODE_ROTATE);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        // Fixed partners in rotate mode; both collapse to i when CHANNELS=1.
        localparam int ROT_DST = (i + 1) % CHANNELS;
        localparam int ROT_SRC = (i + CHANNELS - 1) % CHANNELS;

        logic [7:0]    ram_q [DEPTH];
        logic [AW-1:0] wptr_q, wptr_d;
        logic [AW-1:0] rptr_q, rptr_d;
        logic [LW-1:0] level_q, level_d;
        logic [7:0]    wr_data;

        // Source i is gated only by its destination FIFO being full; sink
        // mode accepts everything. Built from registered state only.
        assign out_ready_o[i] = is_sink | (is_rot ? ~is_full[ROT_DST] : ~is_full[i]);

        // Exactly one source can feed FIFO i in each mode, so no arbitration.
        assign wr_en[i] = ~is_sink & (is_rot ? (out_valid_i[ROT_SRC] & out_ready_o[ROT_SRC])
                                             : (out_valid_i[i] & out_ready_o[i]));
        assign wr_data  = is_rot ? out_data_i[8*ROT_SRC +: 8] : out_data_i[8*i +: 8];

        assign is_full[i]    = (level_q == FULL_LEVEL);
        assign in_valid_o[i] = (level_q != '0);
        assign rd_en[i]      = in_valid_o[i] & in_ready_i[i];

        // Head byte masked to zero while empty, since the RAM is never reset.
        assign in_data_o[8*i +: 8] = in_valid_o[i] ? ram_q[rptr_q] : 8'h00;
        assign level_o[LW*i +: LW] = level_q;

        // Next pointers and occupancy; simultaneous write and read keep level.
        always_comb begin
            wptr_d  = wptr_q;
            rptr_d  = rptr_q;
            level_d = level_q;
            if (wr_en[i]) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (rd_en[i]) begin
                rptr_d = rptr_q + 1'b1;
            end
            case ({wr_en[i], rd_en[i]})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end

        // FIFO control registers, emptied asynchronously on reset.
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                level_q <= '0;
            end else begin
                wptr_q  <= wptr_d;
                rptr_q  <= rptr_d;
                level_q <= level_d;
            end
        end

        // Byte storage; contents are don't-care until written.
        always_ff @(posedge clk_i) begin
            if (wr_en[i]) begin
                ram_q[wptr_q] <= wr_data;
            end
        end
    end

    assign any_xfer  = (|(out_valid_i & out_ready_o)) | (|rd_en);
    assign all_empty = ~|in_valid_o;

    // Mode only switches on a fully idle, empty engine; LED reloads on traffic.
    always_comb begin
        mode_d    = mode_q;
        led_cnt_d = led_cnt_q;
        if (all_empty && !any_xfer) begin
            mode_d = mode_i;
        end
        if (any_xfer) begin
            led_cnt_d = '1;
        end else if (led_cnt_q != '0) begin
            led_cnt_d = led_cnt_q - 1'b1;
        end
    end

    // Mode and LED stretch registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mode_q    <= '0;
            led_cnt_q <= '0;
        end else begin
            mode_q    <= mode_d;
            led_cnt_q <= led_cnt_d;
        end
    end

    assign mode_o = mode_q;
    assign led_o  = |led_cnt_q;

endmodule
`default_nettype wire
